// File: rtl/cmd_sequencer_if.sv
// Bus between the command sequencer and its host/RemoteComm side.
// slave = sequencer view, master = host/bench view.
interface cmd_sequencer_if;
  logic        push;
  logic [15:0] push_cmd;
  logic        full;
  logic        empty;
  logic        start;
  logic        abort;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  n_acked;

  modport slave (
    input  push, push_cmd, start, abort, cmd_snt, resp_rdy, resp,
    output full, empty, cmd, snd_cmd, busy, done, err, err_code, n_acked
  );

  modport master (
    output push, push_cmd, start, abort, cmd_snt, resp_rdy, resp,
    input  full, empty, cmd, snd_cmd, busy, done, err, err_code, n_acked
  );
endinterface

// File: rtl/cmd_sequencer.sv
// Queues Knight move/calibrate commands and plays them to RemoteComm one at a time,
// retiring each only on the positive ack byte; NACK/timeout/abort halt with a sticky error.
module cmd_sequencer #(
  parameter int unsigned      DEPTH   = 8,
  parameter int unsigned      TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = {TMO_W{1'b1}},
  parameter logic [7:0]       ACK     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  cmd_sequencer_if.slave        io_bus
);

  localparam int unsigned      AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned      CW       = AW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYC - TMO_W'(1);

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_NACK  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_SNT,
    ST_WAIT_RESP
  } state_t;

  state_t           r_state;
  logic [15:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_cnt;
  logic [TMO_W-1:0] r_tmo;
  logic             r_pend;
  logic [7:0]       r_pend_byte;

  logic             r_full;
  logic             r_empty;
  logic [15:0]      r_cmd;
  logic             r_snd_cmd;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [1:0]       r_err_code;
  logic [7:0]       r_n_acked;

  logic             w_push;
  logic             w_abort;
  logic             w_resp_vld;
  logic [7:0]       w_resp_byte;
  logic             w_ack;
  logic             w_tmo_hit;
  logic [AW-1:0]    w_rd_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [15:0]      w_head_nxt;

  // A response that arrived alongside cmd_snt is held in r_pend and consumed in WAIT_RESP.
  always_comb begin
    w_push      = io_bus.push && (r_cnt != FULL_CNT);
    w_abort     = io_bus.abort && (r_state != ST_IDLE);
    w_resp_vld  = (r_state == ST_WAIT_RESP) && (io_bus.resp_rdy || r_pend);
    w_resp_byte = r_pend ? r_pend_byte : io_bus.resp;
    w_ack       = w_resp_vld && !w_abort && (w_resp_byte == ACK);
    w_tmo_hit   = (r_tmo >= TMO_LAST);
    w_rd_nxt    = w_ack ? (r_rd + AW'(1)) : r_rd;
    w_cnt_nxt   = r_cnt + CW'(w_push) - CW'(w_ack);
    w_head_nxt  = (w_push && (w_rd_nxt == r_wr)) ? io_bus.push_cmd : r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_pend      <= 1'b0;
      r_pend_byte <= 8'h00;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_cmd       <= 16'h0000;
      r_snd_cmd   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_n_acked   <= 8'h00;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= io_bus.push_cmd;
        r_wr        <= r_wr + AW'(1);
      end
      r_rd    <= w_rd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == FULL_CNT);
      r_empty <= (w_cnt_nxt == '0);
      // Head only moves on a pop or on the first push into an empty FIFO.
      if (w_cnt_nxt != '0) begin
        r_cmd <= w_head_nxt;
      end

      r_snd_cmd <= 1'b0;
      r_done    <= 1'b0;

      if (w_abort) begin
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_err      <= 1'b1;
        r_err_code <= ERR_ABORT;
        r_pend     <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (io_bus.start) begin
              if (r_cnt != '0) begin
                r_err      <= 1'b0;
                r_err_code <= ERR_NONE;
                r_n_acked  <= 8'h00;
                r_state    <= ST_SEND;
                r_busy     <= 1'b1;
                r_snd_cmd  <= 1'b1;
              end else begin
                r_done <= 1'b1;
              end
            end
          end

          ST_SEND: begin
            r_tmo   <= '0;
            r_state <= ST_WAIT_SNT;
          end

          ST_WAIT_SNT: begin
            r_tmo <= r_tmo + TMO_W'(1);
            if (io_bus.cmd_snt) begin
              r_state <= ST_WAIT_RESP;
              if (io_bus.resp_rdy) begin
                r_pend      <= 1'b1;
                r_pend_byte <= io_bus.resp;
              end
            end else if (w_tmo_hit) begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
              r_err_code <= ERR_TMO;
            end
          end

          ST_WAIT_RESP: begin
            r_tmo <= r_tmo + TMO_W'(1);
            if (w_resp_vld) begin
              r_pend <= 1'b0;
              if (w_ack) begin
                if (r_n_acked != 8'hFF) begin
                  r_n_acked <= r_n_acked + 8'd1;
                end
                if (w_cnt_nxt == '0) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                end else begin
                  r_state   <= ST_SEND;
                  r_snd_cmd <= 1'b1;
                end
              end else begin
                r_state    <= ST_IDLE;
                r_busy     <= 1'b0;
                r_err      <= 1'b1;
                r_err_code <= ERR_NACK;
              end
            end else if (w_tmo_hit) begin
              r_state    <= ST_IDLE;
              r_busy     <= 1'b0;
              r_err      <= 1'b1;
              r_err_code <= ERR_TMO;
              r_pend     <= 1'b0;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_bus.full     = r_full;
  assign io_bus.empty    = r_empty;
  assign io_bus.cmd      = r_cmd;
  assign io_bus.snd_cmd  = r_snd_cmd;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.err      = r_err;
  assign io_bus.err_code = r_err_code;
  assign io_bus.n_acked  = r_n_acked;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: a cycle table for the main playout, NACK and abort
// flows, followed by hand-written FIFO-full, timeout and mid-sequence reset sequences.
module tb_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_sequencer_if bus ();

  cmd_sequencer #(
    .DEPTH  (8),
    .TMO_W  (24),
    .TMO_CYC(24'd100),
    .ACK    (8'hA5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  // Expected word layout: {full, empty, busy, snd_cmd, done, err, err_code[1:0], n_acked[7:0], cmd[15:0]}
  typedef struct {
    logic        push;
    logic [15:0] pcmd;
    logic        start;
    logic        abort;
    logic        snt;
    logic        rdy;
    logic [7:0]  resp;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 40;
  localparam logic [31:0] RESET_OUTS = 32'h4000_0000;

  vec_t tv [NV];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic p, input logic [15:0] pc, input logic st, input logic ab,
                              input logic sn, input logic rd, input logic [7:0] rs,
                              input logic f, input logic e, input logic b, input logic s,
                              input logic d, input logic er, input logic [1:0] cd,
                              input logic [7:0] n, input logic [15:0] cm);
    vec_t v;
    v.push  = p;  v.pcmd = pc; v.start = st; v.abort = ab;
    v.snt   = sn; v.rdy  = rd; v.resp  = rs;
    v.exp   = {f, e, b, s, d, er, cd, n, cm};
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {bus.full, bus.empty, bus.busy, bus.snd_cmd, bus.done, bus.err,
            bus.err_code, bus.n_acked, bus.cmd};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [15:0] pc, input logic st, input logic ab,
                       input logic sn, input logic rd, input logic [7:0] rs);
    bus.push = p; bus.push_cmd = pc; bus.start = st; bus.abort = ab;
    bus.cmd_snt = sn; bus.resp_rdy = rd; bus.resp = rs;
  endtask

  // Apply inputs for one clock, sample 1 time unit after the edge, then release them.
  task automatic step(input logic p, input logic [15:0] pc, input logic st, input logic ab,
                      input logic sn, input logic rd, input logic [7:0] rs);
    drive(p, pc, st, ab, sn, rd, rs);
    @(posedge clk);
    #1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    //          push pcmd      st ab sn rd resp    f e b s d er cd  nack cmd
    tv[0]  = mk(1, 16'h2000, 0, 0, 0, 0, 8'h00,  0,0,0,0,0,0, 2'd0, 8'd0, 16'h2000);
    tv[1]  = mk(1, 16'h4001, 0, 0, 0, 0, 8'h00,  0,0,0,0,0,0, 2'd0, 8'd0, 16'h2000);
    tv[2]  = mk(1, 16'h6002, 0, 0, 0, 0, 8'h00,  0,0,0,0,0,0, 2'd0, 8'd0, 16'h2000);
    tv[3]  = mk(0, 16'h0000, 1, 0, 0, 0, 8'h00,  0,0,1,1,0,0, 2'd0, 8'd0, 16'h2000);
    tv[4]  = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd0, 16'h2000);
    tv[5]  = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd0, 16'h2000);
    tv[6]  = mk(0, 16'h0000, 0, 0, 0, 1, 8'hA5,  0,0,1,1,0,0, 2'd0, 8'd1, 16'h4001);
    tv[7]  = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd1, 16'h4001);
    tv[8]  = mk(0, 16'h0000, 0, 0, 1, 1, 8'hA5,  0,0,1,0,0,0, 2'd0, 8'd1, 16'h4001);
    tv[9]  = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,0,1,1,0,0, 2'd0, 8'd2, 16'h6002);
    tv[10] = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd2, 16'h6002);
    tv[11] = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd2, 16'h6002);
    tv[12] = mk(0, 16'h0000, 0, 0, 0, 1, 8'hA5,  0,1,0,0,1,0, 2'd0, 8'd3, 16'h6002);
    tv[13] = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,1,0,0,0,0, 2'd0, 8'd3, 16'h6002);
    tv[14] = mk(0, 16'h0000, 1, 0, 0, 0, 8'h00,  0,1,0,0,1,0, 2'd0, 8'd3, 16'h6002);
    tv[15] = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,1,0,0,0,0, 2'd0, 8'd3, 16'h6002);
    tv[16] = mk(1, 16'h1111, 0, 0, 0, 0, 8'h00,  0,0,0,0,0,0, 2'd0, 8'd3, 16'h1111);
    tv[17] = mk(1, 16'h2222, 0, 0, 0, 0, 8'h00,  0,0,0,0,0,0, 2'd0, 8'd3, 16'h1111);
    tv[18] = mk(1, 16'h3333, 0, 0, 0, 0, 8'h00,  0,0,0,0,0,0, 2'd0, 8'd3, 16'h1111);
    tv[19] = mk(0, 16'h0000, 1, 0, 0, 0, 8'h00,  0,0,1,1,0,0, 2'd0, 8'd0, 16'h1111);
    tv[20] = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd0, 16'h1111);
    tv[21] = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd0, 16'h1111);
    tv[22] = mk(0, 16'h0000, 0, 0, 0, 1, 8'hA5,  0,0,1,1,0,0, 2'd0, 8'd1, 16'h2222);
    tv[23] = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd1, 16'h2222);
    tv[24] = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd1, 16'h2222);
    tv[25] = mk(0, 16'h0000, 0, 0, 0, 1, 8'h5A,  0,0,0,0,0,1, 2'd1, 8'd1, 16'h2222);
    tv[26] = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,0,0,0,0,1, 2'd1, 8'd1, 16'h2222);
    tv[27] = mk(0, 16'h0000, 1, 0, 0, 0, 8'h00,  0,0,1,1,0,0, 2'd0, 8'd0, 16'h2222);
    tv[28] = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd0, 16'h2222);
    tv[29] = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd0, 16'h2222);
    tv[30] = mk(0, 16'h0000, 0, 1, 0, 1, 8'hA5,  0,0,0,0,0,1, 2'd3, 8'd0, 16'h2222);
    tv[31] = mk(0, 16'h0000, 0, 1, 0, 0, 8'h00,  0,0,0,0,0,1, 2'd3, 8'd0, 16'h2222);
    tv[32] = mk(0, 16'h0000, 1, 0, 0, 0, 8'h00,  0,0,1,1,0,0, 2'd0, 8'd0, 16'h2222);
    tv[33] = mk(0, 16'h0000, 0, 0, 0, 1, 8'hA5,  0,0,1,0,0,0, 2'd0, 8'd0, 16'h2222);
    tv[34] = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd0, 16'h2222);
    tv[35] = mk(0, 16'h0000, 0, 0, 0, 1, 8'hA5,  0,0,1,1,0,0, 2'd0, 8'd1, 16'h3333);
    tv[36] = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd1, 16'h3333);
    tv[37] = mk(0, 16'h0000, 0, 0, 1, 0, 8'h00,  0,0,1,0,0,0, 2'd0, 8'd1, 16'h3333);
    tv[38] = mk(0, 16'h0000, 0, 0, 0, 1, 8'hA5,  0,1,0,0,1,0, 2'd0, 8'd2, 16'h3333);
    tv[39] = mk(0, 16'h0000, 0, 0, 0, 0, 8'h00,  0,1,0,0,0,0, 2'd0, 8'd2, 16'h3333);

    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), RESET_OUTS);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step(tv[i].push, tv[i].pcmd, tv[i].start, tv[i].abort, tv[i].snt, tv[i].rdy, tv[i].resp);
      check($sformatf("vec%0d", i), outs(), tv[i].exp);
    end

    // Nine pushes into an 8-deep FIFO: the ninth is dropped.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      if (i == 6) check("full_after_7", 32'(bus.full), 32'd0);
      if (i == 7) check("full_after_8", 32'(bus.full), 32'd1);
    end
    check("full_after_9", 32'(bus.full), 32'd1);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_snd%0d", i), 32'(bus.snd_cmd), 32'd1);
      check($sformatf("fill_cmd%0d", i), 32'(bus.cmd), 32'hA000 + 32'(i));
      idle();
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
    end
    check("fill_done", 32'(bus.done), 32'd1);
    check("fill_nacked", 32'(bus.n_acked), 32'd8);
    check("fill_empty", 32'(bus.empty), 32'd1);
    idle();
    check("fill_no_ninth", {30'd0, bus.busy, bus.snd_cmd}, 32'd0);

    // Timeout: resp_rdy never arrives, TMO_CYC = 100.
    step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("tmo_snd", 32'(bus.snd_cmd), 32'd1);
    idle();
    step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    repeat (98) idle();
    check("tmo_not_yet", {30'd0, bus.busy, bus.err}, 32'd2);
    idle();
    check("tmo_fired", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 8'd0, 16'h7777});

    // Reset while waiting for cmd_snt.
    step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_restart_snd", {30'd0, bus.snd_cmd, bus.err}, 32'd2);
    idle();
    check("rst_in_wait_snt", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("rst_mid_seq", outs(), RESET_OUTS);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5);
      check($sformatf("rst_quiet%0d", i), outs(), RESET_OUTS);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
